// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage and the main decoder.
package cpu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 3'd0;
    localparam logic [OP_W-1:0] OP_LW    = 3'd1;
    localparam logic [OP_W-1:0] OP_SW    = 3'd2;
    localparam logic [OP_W-1:0] OP_BEQ   = 3'd3;
    localparam logic [OP_W-1:0] OP_ADDI  = 3'd4;
    localparam logic [OP_W-1:0] OP_J     = 3'd5;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem request at a time and
// holds the returned instruction for decode; redirects squash the wrong path.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned   AW       = 8,
    parameter int unsigned   IW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [IW-1:0] imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic [2:0]    op,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc
);

    generate
        if (IW < 4) begin : g_iw_check
            $error("fetch_unit: IW must be at least 4");
        end
    endgenerate

    fetch_state_t  state;
    logic [AW-1:0] pc;
    logic          drop;

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_HOLD);
    assign op          = instr[IW-1 -: OP_W];

    // Redirect outranks every other event; drop marks a response owed by
    // a request that was issued down the abandoned path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            instr    <= '0;
            instr_pc <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        state <= S_WAIT;
                        drop  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                S_HOLD:  state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            instr    <= imem_rdata;
                            instr_pc <= pc;
                            pc       <= pc + AW'(1);
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Read data may only arrive while a request is outstanding.
    a_rvalid_only_in_wait: assert property (
        @(posedge clk) disable iff (reset) imem_rvalid |-> (state == S_WAIT)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a random-latency memory model plus a
// delivered-instruction stream model (next pc = last+1, or redirect target).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic [2:0]  op;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;

    fetch_unit #(.AW(8), .IW(16), .RESET_PC(8'h00)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .op             (op),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [256];
    logic        outstanding;
    logic [7:0]  out_addr;
    int          lat;
    int          gnt_pct;
    int          lat_min;
    int          lat_max;
    logic [7:0]  exp_pc;

    // One clock: drive inputs, check, take the edge, advance the models.
    task automatic cycle(input logic rdy, input logic redir, input logic [7:0] rpc);
        logic        g;
        logic        rv;
        logic        acc;
        logic [7:0]  a;
        logic [15:0] e;
        logic [2:0]  eop;
        a  = imem_addr;
        g  = imem_req && !outstanding && ($urandom_range(99) < 32'(gnt_pct));
        rv = outstanding && (lat == 0);
        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem[out_addr] : 16'($urandom);
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        checks++;
        if (outstanding && imem_req) begin
            errors++;
            $display("FAIL second_outstanding req=%b while response owed", imem_req);
        end
        if (imem_req) begin
            checks++;
            if (imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL req_addr got %h exp %h", imem_addr, exp_pc);
            end
        end
        acc = instr_valid && rdy;
        if (acc) begin
            e   = mem[exp_pc];
            eop = e[15:13];
            checks++;
            if (instr_pc !== exp_pc || instr !== e || op !== eop) begin
                errors++;
                $display("FAIL deliver got pc=%h instr=%h op=%h exp pc=%h instr=%h op=%h",
                         instr_pc, instr, op, exp_pc, e, eop);
            end
        end
        @(posedge clk);
        if (g) begin
            outstanding = 1'b1;
            out_addr    = a;
            lat         = int'($urandom_range(32'(lat_max - 1), 32'(lat_min - 1)));
        end else if (rv) begin
            outstanding = 1'b0;
        end else if (outstanding) begin
            lat--;
        end
        if (redir)    exp_pc = rpc;
        else if (acc) exp_pc = exp_pc + 8'd1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        outstanding = 1'b0; lat = 0; exp_pc = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 8'h0 || imem_addr !== 8'h0) begin
            errors++;
            $display("FAIL reset_values valid=%b instr=%h pc=%h addr=%h exp 0", instr_valid, instr, instr_pc, imem_addr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_req got %b exp 1", imem_req);
        end
    endtask

    task automatic test_first_fetch();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h2005 || op !== 3'b001 || instr_pc !== 8'h00 || imem_addr !== 8'h01) begin
            errors++;
            $display("FAIL first_fetch valid=%b instr=%h op=%h pc=%h addr=%h exp 1 2005 1 00 01",
                     instr_valid, instr, op, instr_pc, imem_addr);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 16'h2005 || op !== 3'b001 || instr_pc !== 8'h00) begin
                errors++;
                $display("FAIL stall_hold valid=%b req=%b instr=%h op=%h pc=%h", instr_valid, imem_req, instr, op, instr_pc);
            end
        end
        cycle(1'b1, 1'b0, 8'h00);
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h01) begin
            errors++;
            $display("FAIL after_accept valid=%b req=%b addr=%h exp 0 1 01", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h40);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
            errors++;
            $display("FAIL redirect_wait valid=%b req=%b addr=%h exp 0 1 40", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_gnt();
        gnt_pct = 0;
        cycle(1'b0, 1'b1, 8'h03);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h03) begin
            errors++;
            $display("FAIL redirect_req got req=%b addr=%h exp 1 03", imem_req, imem_addr);
        end
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        cycle(1'b0, 1'b1, 8'h10);
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 8'h10) begin
            errors++;
            $display("FAIL redirect_gnt_drop valid=%b addr=%h exp 0 10", instr_valid, imem_addr);
        end
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h10) begin
            errors++;
            $display("FAIL redirect_gnt_fetch valid=%b pc=%h exp 1 10", instr_valid, instr_pc);
        end
        cycle(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_wrap_and_hold_redirect();
        gnt_pct = 0;
        cycle(1'b0, 1'b1, 8'hFF);
        gnt_pct = 100;
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'hFF || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL wrap valid=%b pc=%h addr=%h exp 1 ff 00", instr_valid, instr_pc, imem_addr);
        end
        cycle(1'b1, 1'b1, 8'h20);
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h20) begin
            errors++;
            $display("FAIL hold_redirect valid=%b req=%b addr=%h exp 0 1 20", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        cycle(1'b0, 1'b0, 8'h00);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 8'h0 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL async_reset valid=%b instr=%h pc=%h addr=%h exp 0", instr_valid, instr, instr_pc, imem_addr);
        end
        outstanding = 1'b0; lat = 0; exp_pc = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_restart req=%b addr=%h exp 1 00", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        logic       rdy;
        logic       rd;
        logic [7:0] tgt;
        gnt_pct = 60; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(99) < 50);
            rd  = ($urandom_range(99) < 8);
            tgt = 8'($urandom);
            cycle(rdy, rd, tgt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h00] = 16'h2005;
        mem[8'h01] = 16'hFFFF;
        mem[8'hFF] = 16'hA5C3;
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap_and_hold_redirect();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
